// File: rtl/viewport_scaler.sv
// Viewport scaling stage: scales X/Y of a vertex batch by fixed-point factors, rounds,
// offsets and saturates, using one time-multiplexed multiplier. Z passes through.
module viewport_scaler #(
  parameter int DATA_W  = 21,
  parameter int FRAC_W  = 18,
  parameter int NUM_VTX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             scale_x,
  input  logic [DATA_W-1:0]             scale_y,
  input  logic [DATA_W-1:0]             off_x,
  input  logic [DATA_W-1:0]             off_y,
  input  logic [NUM_VTX*3*DATA_W-1:0]   in_vtx,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_VTX*3*DATA_W-1:0]   out_vtx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sat_flag
);

  localparam int VEC_W = NUM_VTX * 3 * DATA_W;
  localparam int NPROD = 2 * NUM_VTX;
  localparam int CNT_W = $clog2(NPROD);
  localparam int IDX_W = $clog2(VEC_W);
  localparam int P_W   = 2 * DATA_W + 2;

  localparam logic [CNT_W-1:0]        LAST   = CNT_W'(NPROD - 1);
  localparam logic [VEC_W-1:0]        Z_MASK = {NUM_VTX{{DATA_W{1'b1}}, {(2*DATA_W){1'b0}}}};
  localparam logic signed [P_W-1:0]   HALF   = {{(P_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [P_W-1:0]   MAX_S  = {{(P_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [P_W-1:0]   MIN_S  = {{(P_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VEC_W-1:0]    vtx_q, vtx_d;
  logic [VEC_W-1:0]    out_vtx_q, out_vtx_d;
  logic [DATA_W-1:0]   scale_x_q, scale_x_d, scale_y_q, scale_y_d;
  logic [DATA_W-1:0]   off_x_q, off_x_d, off_y_q, off_y_d;
  logic                sat_q, sat_d;

  // Shared datapath: one product per MUL cycle, selected by the index counter.
  logic [IDX_W-1:0]        base;
  logic [DATA_W-1:0]       coord, scale_sel, off_sel, res;
  logic signed [P_W-1:0]   coord_w, scale_w, off_w, prod, rnd, scaled, sum;
  logic                    clamp;

  always_comb begin
    base      = IDX_W'(32'(cnt_q >> 1) * (3 * DATA_W) + (cnt_q[0] ? DATA_W : 0));
    coord     = vtx_q[base +: DATA_W];
    scale_sel = cnt_q[0] ? scale_y_q : scale_x_q;
    off_sel   = cnt_q[0] ? off_y_q : off_x_q;
    coord_w   = {{(P_W-DATA_W){coord[DATA_W-1]}}, coord};
    scale_w   = {{(P_W-DATA_W){1'b0}}, scale_sel};
    off_w     = {{(P_W-DATA_W){off_sel[DATA_W-1]}}, off_sel};
    prod      = coord_w * scale_w;
    rnd       = prod + HALF;
    scaled    = rnd >>> FRAC_W;
    sum       = scaled + off_w;
    clamp     = 1'b0;
    res       = sum[DATA_W-1:0];
    if (sum > MAX_S) begin
      res   = {1'b0, {(DATA_W-1){1'b1}}};
      clamp = 1'b1;
    end else if (sum < MIN_S) begin
      res   = {1'b1, {(DATA_W-1){1'b0}}};
      clamp = 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vtx_d     = vtx_q;
    out_vtx_d = out_vtx_q;
    scale_x_d = scale_x_q;
    scale_y_d = scale_y_q;
    off_x_d   = off_x_q;
    off_y_d   = off_y_q;
    sat_d     = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vtx_d     = in_vtx;
          scale_x_d = scale_x;
          scale_y_d = scale_y;
          off_x_d   = off_x;
          off_y_d   = off_y;
          out_vtx_d = (out_vtx_q & ~Z_MASK) | (in_vtx & Z_MASK);
          cnt_d     = '0;
          sat_d     = 1'b0;
          state_d   = MUL;
        end
      end
      MUL: begin
        out_vtx_d[base +: DATA_W] = res;
        sat_d = sat_q | clamp;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vtx_q     <= '0;
      out_vtx_q <= '0;
      scale_x_q <= '0;
      scale_y_q <= '0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vtx_q     <= vtx_d;
      out_vtx_q <= out_vtx_d;
      scale_x_q <= scale_x_d;
      scale_y_q <= scale_y_d;
      off_x_q   <= off_x_d;
      off_y_q   <= off_y_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_vtx   = out_vtx_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_viewport_scaler.sv
// Directed bench for viewport_scaler: rounding, offset, saturation, backpressure,
// reset mid-batch and back-to-back throughput against hand-computed results.
module tb_viewport_scaler;

  localparam int DW = 21;
  localparam int NV = 4;
  localparam int VW = NV * 3 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] scale_x, scale_y, off_x, off_y;
  logic [VW-1:0] in_vtx, out_vtx;
  logic          in_valid, in_ready, out_valid, out_ready, sat_flag;

  int total = 0;
  int bad   = 0;

  int ax[4], ay[4], az[4], ex[4], ey[4];
  logic [VW-1:0] exp_v;

  int bx[5][4]  = '{'{0, 1, 2, 3}, '{-10, -20, 30, 40}, '{1000, -1000, 0, 7}, '{5, 6, 7, 8}, '{-5, -6, -7, -8}};
  int by[5][4]  = '{'{1, 3, -1, -3}, '{10, -10, 5, -5}, '{100, -100, 0, 7}, '{2, 4, 6, 8}, '{-2, -4, -6, -8}};
  int bz[5][4]  = '{'{7, 8, 9, 10}, '{-1, -2, -3, -4}, '{0, 0, 0, 0}, '{11, 22, 33, 44}, '{1, 2, 3, 4}};
  int ebx[5][4] = '{'{10, 11, 12, 13}, '{0, -10, 40, 50}, '{1010, -990, 10, 17}, '{15, 16, 17, 18}, '{5, 4, 3, 2}};
  int eby[5][4] = '{'{-4, -3, -5, -6}, '{0, -10, -2, -7}, '{45, -55, -5, -1}, '{-4, -3, -2, -1}, '{-6, -7, -8, -9}};

  viewport_scaler #(.DATA_W(DW), .FRAC_W(18), .NUM_VTX(NV)) dut (
    .clk       (clk),
    .rst       (rst),
    .scale_x   (scale_x),
    .scale_y   (scale_y),
    .off_x     (off_x),
    .off_y     (off_y),
    .in_vtx    (in_vtx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_vtx   (out_vtx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pk(input int x[4], input int y[4], input int z[4]);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NV; i++) begin
      r[i*3*DW +: DW]        = DW'(x[i]);
      r[i*3*DW + DW +: DW]   = DW'(y[i]);
      r[i*3*DW + 2*DW +: DW] = DW'(z[i]);
    end
    return r;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s: observed=%b expected=%b", tag, obs, expv);
      $error("%s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      $error("%s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      $error("%s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [VW-1:0] v, input logic [DW-1:0] sx, input logic [DW-1:0] sy,
                        input logic [DW-1:0] ox, input logic [DW-1:0] oy);
    in_vtx   = v;
    scale_x  = sx;
    scale_y  = sy;
    off_x    = ox;
    off_y    = oy;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_bit("accept_ready_low", in_ready, 1'b0);
  endtask

  // Counts edges after the accept edge until out_valid; 8 is the required latency.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_int(tag, n, 8);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_bit("hs_valid_drop", out_valid, 1'b0);
    check_bit("hs_ready_back", in_ready, 1'b1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vtx = '0;
    scale_x = '0; scale_y = '0; off_x = '0; off_y = '0;
    tick();
    tick();
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_out_vtx", out_vtx, '0);
    check_bit("rst_sat", sat_flag, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("rel_in_ready", in_ready, 1'b1);

    // Default rounding (round half toward +inf)
    ax = '{100, 2, -3, -2};  ay = '{1, -2, 16, -8};  az = '{5, -6, 7, -8};
    ex = '{125, 3, -4, -2};  ey = '{1, -2, 15, -7};
    accept(pk(ax, ay, az), 21'h50000, 21'h3C000, '0, '0);
    wait_valid("round_latency");
    check_vec("round_vtx", out_vtx, pk(ex, ey, az));
    check_bit("round_sat", sat_flag, 1'b0);
    handshake();

    // Saturation at both rails, Z untouched
    ax = '{1048575, -1048576, 0, 10};  ay = '{5, -5, 0, 0};  az = '{1048575, -1048576, 74565, 0};
    ex = '{1048575, -1048576, 0, 13};  ey = '{5, -5, 0, 0};
    accept(pk(ax, ay, az), 21'h50000, 21'h40000, '0, '0);
    wait_valid("sat_latency");
    check_vec("sat_vtx", out_vtx, pk(ex, ey, az));
    check_bit("sat_flag_set", sat_flag, 1'b1);
    handshake();
    check_bit("sat_flag_hold", sat_flag, 1'b1);

    // Offsets
    ax = '{-256, 0, 100, -320};  ay = '{0, 16, -16, -256};  az = '{1, 2, 3, 4};
    ex = '{64, 320, 420, 0};     ey = '{240, 255, 225, 0};
    accept(pk(ax, ay, az), 21'h40000, 21'h3C000, DW'(320), DW'(240));
    check_bit("sat_clear_on_accept", sat_flag, 1'b0);
    wait_valid("off_latency");
    check_vec("off_vtx", out_vtx, pk(ex, ey, az));
    check_bit("off_sat", sat_flag, 1'b0);
    handshake();

    // Backpressure: config and input change during MUL and DONE must not leak in
    ax = '{1, 2, 3, 4};  ay = '{5, 6, 7, 8};  az = '{9, 10, 11, 12};
    exp_v = pk(ax, ay, az);
    accept(exp_v, 21'h40000, 21'h40000, '0, '0);
    scale_x = 21'h80000; scale_y = 21'h10000; off_x = DW'(100); off_y = DW'(-100);
    in_vtx  = '1;
    wait_valid("bp_latency");
    check_vec("bp_vtx", out_vtx, exp_v);
    ax = '{100, 2, -3, -2};  ay = '{1, -2, 16, -8};  az = '{5, -6, 7, -8};
    accept_pending: begin
      in_vtx = pk(ax, ay, az); scale_x = 21'h50000; scale_y = 21'h3C000; off_x = '0; off_y = '0;
      in_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      check_bit("bp_valid_held", out_valid, 1'b1);
      check_bit("bp_ready_low", in_ready, 1'b0);
      check_vec("bp_vtx_stable", out_vtx, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_bit("bp_hs_valid_drop", out_valid, 1'b0);
    check_bit("bp_hs_ready", in_ready, 1'b1);
    check_vec("bp_vtx_hold", out_vtx, exp_v);
    tick();
    in_valid = 1'b0;
    check_bit("bp_next_accept", in_ready, 1'b0);

    // Reset mid-MUL: batch discarded, no out_valid pulse
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_bit("mid_rst_in_ready", in_ready, 1'b0);
    check_bit("mid_rst_out_valid", out_valid, 1'b0);
    check_vec("mid_rst_out_vtx", out_vtx, '0);
    check_bit("mid_rst_sat", sat_flag, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("mid_rst_ready_after", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    check_int("mid_rst_no_valid", seen, 0);

    // Back-to-back: accepts exactly 10 edges apart
    in_vtx = pk(bx[0], by[0], bz[0]);
    scale_x = 21'h40000; scale_y = 21'h20000; off_x = DW'(10); off_y = DW'(-5);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_bit("b2b_accept", in_ready, 1'b0);
      if (k < 4) in_vtx = pk(bx[k+1], by[k+1], bz[k+1]);
      else       in_valid = 1'b0;
      wait_valid("b2b_latency");
      check_vec("b2b_vtx", out_vtx, pk(ebx[k], eby[k], bz[k]));
      check_bit("b2b_sat", sat_flag, 1'b0);
      tick();
      check_bit("b2b_valid_drop", out_valid, 1'b0);
      check_bit("b2b_ready_back", in_ready, 1'b1);
    end
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
